// File: rtl/hazard_sequencer.sv
// hazard_sequencer: execute-stage pipeline controller.
// Generates operand forwarding selects, load-use / PC-write hazard stalls and flushes,
// and a multi-cycle ALU sequencer that holds execute for MUL_CYCLES cycles.
// Optional statistics counters are built when HAZARD_STATS_EN is defined;
// otherwise StallCount/FlushCount are tied to zero and no counter flops exist.

// One forwarding lane: memory stage beats writeback, r15 is not special.
module hazard_fwd_lane (
  input  logic [3:0] ra,
  input  logic [3:0] wa3m,
  input  logic [3:0] wa3w,
  input  logic       reg_write_m,
  input  logic       reg_write_w,
  output logic [1:0] fwd
);
  // Priority select of the youngest in-flight producer.
  always_comb begin
    fwd = 2'b00;
    if (reg_write_m && (ra == wa3m))      fwd = 2'b10;
    else if (reg_write_w && (ra == wa3w)) fwd = 2'b01;
  end
endmodule

module hazard_sequencer #(
  parameter int MUL_CYCLES = 3,
  parameter int CNT_W      = 4
) (
  input  logic        Clk,
  input  logic        reset,
  input  logic [3:0]  RA1D,
  input  logic [3:0]  RA2D,
  input  logic [3:0]  RA1E,
  input  logic [3:0]  RA2E,
  input  logic [3:0]  WA3E,
  input  logic [3:0]  WA3M,
  input  logic [3:0]  WA3W,
  input  logic        RegWriteM,
  input  logic        RegWriteW,
  input  logic        MemToRegE,
  input  logic        PCSrcD,
  input  logic        PCSrcE,
  input  logic        PCSrcM,
  input  logic        PCSrcW,
  input  logic        BranchTakenE,
  input  logic        MulStartE,
  output logic [1:0]  ForwardAE,
  output logic [1:0]  ForwardBE,
  output logic        StallF,
  output logic        StallD,
  output logic        StallE,
  output logic        FlushD,
  output logic        FlushE,
  output logic        FlushM,
  output logic        MulBusy,
  output logic        MulDoneE,
  output logic [15:0] StallCount,
  output logic [15:0] FlushCount
);
  localparam int NUM_LANES = 2;

  typedef enum logic {RUN = 1'b0, MULWAIT = 1'b1} state_t;

  state_t             state_q, state_d, state_eff;
  logic [CNT_W-1:0]   cnt_q, cnt_d, cnt_eff;
  logic               mul_stall, mul_done;
  logic               ldr_stall, pc_wr_pend;

  logic [NUM_LANES-1:0][3:0] ra_e;
  logic [NUM_LANES-1:0][1:0] fwd;

  // ---------------- forwarding ----------------
  assign ra_e = {RA2E, RA1E};

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_fwd
    hazard_fwd_lane u_lane (
      .ra          (ra_e[l]),
      .wa3m        (WA3M),
      .wa3w        (WA3W),
      .reg_write_m (RegWriteM),
      .reg_write_w (RegWriteW),
      .fwd         (fwd[l])
    );
  end

  assign ForwardAE = fwd[0];
  assign ForwardBE = fwd[1];

  // ---------------- sequencer ----------------
  // While reset is held low the outputs behave as if the sequencer were idle.
  always_comb begin
    state_eff = reset ? state_q : RUN;
    cnt_eff   = reset ? cnt_q   : '0;
  end

  // Next-state, wait counter and multi-cycle stall/done decode.
  always_comb begin
    state_d   = state_eff;
    cnt_d     = cnt_eff;
    mul_stall = 1'b0;
    mul_done  = 1'b0;
    case (state_eff)
      RUN: begin
        if (MulStartE) begin
          mul_stall = 1'b1;
          cnt_d     = CNT_W'(MUL_CYCLES - 2);
          state_d   = MULWAIT;
        end
      end
      MULWAIT: begin
        if (cnt_eff != '0) begin
          mul_stall = 1'b1;
          cnt_d     = cnt_eff - 1'b1;
        end else begin
          mul_done  = 1'b1;
          state_d   = RUN;
        end
      end
      default: state_d = RUN;
    endcase
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge Clk) begin
    if (!reset) begin
      state_q <= RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign MulBusy  = (state_eff == MULWAIT);
  assign MulDoneE = mul_done;

  // ---------------- hazards ----------------
  assign ldr_stall  = MemToRegE & ((RA1D == WA3E) | (RA2D == WA3E));
  assign pc_wr_pend = PCSrcD | PCSrcE | PCSrcM;

  // A stalled execute must keep its instruction, so its flush is suppressed.
  assign StallF = ldr_stall | pc_wr_pend | mul_stall;
  assign StallD = ldr_stall | mul_stall;
  assign StallE = mul_stall;
  assign FlushD = (pc_wr_pend | PCSrcW | BranchTakenE) & ~mul_stall;
  assign FlushE = (ldr_stall | BranchTakenE) & ~StallE;
  assign FlushM = mul_stall;

  // ---------------- statistics ----------------
`ifdef HAZARD_STATS_EN
  logic [15:0] stall_cnt_q, flush_cnt_q;

  // Saturating event counters.
  always_ff @(posedge Clk) begin
    if (!reset) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (StallF && (stall_cnt_q != 16'hFFFF)) stall_cnt_q <= stall_cnt_q + 16'd1;
      if (FlushE && (flush_cnt_q != 16'hFFFF)) flush_cnt_q <= flush_cnt_q + 16'd1;
    end
  end

  assign StallCount = stall_cnt_q;
  assign FlushCount = flush_cnt_q;
`else
  assign StallCount = 16'd0;
  assign FlushCount = 16'd0;
`endif

endmodule

// File: tb/tb_hazard_sequencer.sv
// Self-checking bench for hazard_sequencer: directed literal checks plus a
// randomized run compared every cycle against a position-in-op reference model.
module tb_hazard_sequencer;
  localparam int MC = 3;

  logic        Clk = 1'b0;
  logic        reset;
  logic [3:0]  RA1D, RA2D, RA1E, RA2E, WA3E, WA3M, WA3W;
  logic        RegWriteM, RegWriteW, MemToRegE;
  logic        PCSrcD, PCSrcE, PCSrcM, PCSrcW, BranchTakenE, MulStartE;
  logic [1:0]  ForwardAE, ForwardBE;
  logic        StallF, StallD, StallE, FlushD, FlushE, FlushM, MulBusy, MulDoneE;
  logic [15:0] StallCount, FlushCount;

  int errors = 0;
  int checks = 0;
  bit chk_en = 0;

  // Reference model state: index of the current cycle inside a multi-cycle op (-1 idle)
  int m_pos = -1;
  int m_stall_cnt = 0;
  int m_flush_cnt = 0;

  hazard_sequencer #(.MUL_CYCLES(MC), .CNT_W(4)) dut (
    .Clk(Clk), .reset(reset),
    .RA1D(RA1D), .RA2D(RA2D), .RA1E(RA1E), .RA2E(RA2E),
    .WA3E(WA3E), .WA3M(WA3M), .WA3W(WA3W),
    .RegWriteM(RegWriteM), .RegWriteW(RegWriteW), .MemToRegE(MemToRegE),
    .PCSrcD(PCSrcD), .PCSrcE(PCSrcE), .PCSrcM(PCSrcM), .PCSrcW(PCSrcW),
    .BranchTakenE(BranchTakenE), .MulStartE(MulStartE),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .StallF(StallF), .StallD(StallD), .StallE(StallE),
    .FlushD(FlushD), .FlushE(FlushE), .FlushM(FlushM),
    .MulBusy(MulBusy), .MulDoneE(MulDoneE),
    .StallCount(StallCount), .FlushCount(FlushCount)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    int fa, fb;
    bit sf, sd, se, fd, fe, fm, busy, done;
    int pos;
  } exp_t;

  function automatic int fwd_of(input logic [3:0] ra);
    if (RegWriteM && ra == WA3M) return 2;
    if (RegWriteW && ra == WA3W) return 1;
    return 0;
  endfunction

  function automatic exp_t model();
    exp_t e;
    bit ldr, pcw, ms;
    int p;
    p = reset ? m_pos : -1;
    if (p < 0 && MulStartE) p = 0;
    ms = (p >= 0) && (p < MC - 1);
    ldr = MemToRegE && (RA1D == WA3E || RA2D == WA3E);
    pcw = PCSrcD || PCSrcE || PCSrcM;
    e.fa = fwd_of(RA1E);
    e.fb = fwd_of(RA2E);
    e.sf = ldr || pcw || ms;
    e.sd = ldr || ms;
    e.se = ms;
    e.fd = (pcw || PCSrcW || BranchTakenE) && !ms;
    e.fe = (ldr || BranchTakenE) && !ms;
    e.fm = ms;
    e.busy = (p >= 1);
    e.done = (p == MC - 1);
    e.pos = p;
    return e;
  endfunction

  function automatic logic [13:0] pack_exp(input exp_t e);
    return {2'(e.fa), 2'(e.fb), e.sf, e.sd, e.se, e.fd, e.fe, e.fm, e.busy, e.done};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // Advance the model on each clock edge from the pre-edge inputs.
  always @(posedge Clk) begin
    exp_t e;
    e = model();
    if (!reset) begin
      m_pos <= -1;
      m_stall_cnt <= 0;
      m_flush_cnt <= 0;
    end else begin
      m_pos <= (e.pos < 0 || e.done) ? -1 : e.pos + 1;
`ifdef HAZARD_STATS_EN
      if (e.sf && m_stall_cnt < 65535) m_stall_cnt <= m_stall_cnt + 1;
      if (e.fe && m_flush_cnt < 65535) m_flush_cnt <= m_flush_cnt + 1;
`endif
    end
  end

  // Compare every cycle, mid-period.
  always @(negedge Clk) begin
    if (chk_en) begin
      logic [13:0] act;
      act = {ForwardAE, ForwardBE, StallF, StallD, StallE, FlushD, FlushE, FlushM, MulBusy, MulDoneE};
      chk("model_outs", 32'(act), 32'(pack_exp(model())));
      chk("model_stallcnt", 32'(StallCount), 32'(m_stall_cnt));
      chk("model_flushcnt", 32'(FlushCount), 32'(m_flush_cnt));
    end
  end

  task automatic clr();
    {RA1D, RA2D, RA1E, RA2E, WA3E, WA3M, WA3W} = '0;
    {RegWriteM, RegWriteW, MemToRegE, PCSrcD, PCSrcE, PCSrcM, PCSrcW, BranchTakenE, MulStartE} = '0;
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  initial begin
    exp_t e;
    clr();
    reset = 1'b0;
    step();
    chk_en = 1;
    step();
    // Reset state
    @(negedge Clk);
    chk("rst_busy", 32'(MulBusy), 0);
    chk("rst_stallcnt", 32'(StallCount), 0);
    reset = 1'b1;

    // Forwarding priority
    step();
    RegWriteM = 1; WA3M = 3; RegWriteW = 1; WA3W = 3; RA1E = 3; RA2E = 5;
    @(negedge Clk);
    chk("fwdA_mem", 32'(ForwardAE), 2);
    chk("fwdB_none", 32'(ForwardBE), 0);
    e = model();
    chk("model_fwdA_pin", 32'(e.fa), 2);
    step();
    RegWriteM = 0;
    @(negedge Clk);
    chk("fwdA_wb", 32'(ForwardAE), 1);

    // Load-use
    step(); clr();
    MemToRegE = 1; WA3E = 2; RA2D = 2; RA1D = 7;
    @(negedge Clk);
    chk("ldr_stallf", 32'(StallF), 1);
    chk("ldr_stalld", 32'(StallD), 1);
    chk("ldr_flushe", 32'(FlushE), 1);
    chk("ldr_flushd", 32'(FlushD), 0);
    step(); clr();

    // Multi-cycle op, MUL_CYCLES = 3
    step(); MulStartE = 1;
    @(negedge Clk);
    chk("mul_c0_stalle", 32'(StallE), 1);
    chk("mul_c0_flushm", 32'(FlushM), 1);
    chk("mul_c0_busy", 32'(MulBusy), 0);
    step();
    @(negedge Clk);
    chk("mul_c1_stalle", 32'(StallE), 1);
    chk("mul_c1_busy", 32'(MulBusy), 1);
    step();
    @(negedge Clk);
    chk("mul_c2_stalle", 32'(StallE), 0);
    chk("mul_c2_done", 32'(MulDoneE), 1);
    step(); MulStartE = 0;
    @(negedge Clk);
    chk("mul_c3_busy", 32'(MulBusy), 0);
    chk("mul_c3_done", 32'(MulDoneE), 0);
`ifdef HAZARD_STATS_EN
    chk("stats_stall", 32'(StallCount), 3);
    chk("stats_flush", 32'(FlushCount), 1);
`else
    chk("stats_stall_off", 32'(StallCount), 0);
    chk("stats_flush_off", 32'(FlushCount), 0);
`endif

    // Branch taken
    step(); clr(); BranchTakenE = 1;
    @(negedge Clk);
    chk("br_flushd", 32'(FlushD), 1);
    chk("br_flushe", 32'(FlushE), 1);
    chk("br_stalls", 32'({StallF, StallD, StallE}), 0);

    // PC write walking through the pipe
    step(); clr(); PCSrcD = 1;
    @(negedge Clk);
    chk("pcD", 32'({StallF, FlushD}), 3);
    step(); clr(); PCSrcE = 1;
    @(negedge Clk);
    chk("pcE", 32'({StallF, FlushD}), 3);
    step(); clr(); PCSrcM = 1;
    @(negedge Clk);
    chk("pcM", 32'({StallF, FlushD}), 3);
    step(); clr(); PCSrcW = 1;
    @(negedge Clk);
    chk("pcW", 32'({StallF, FlushD}), 1);

    // Reset in the middle of a sequence
    step(); clr(); MulStartE = 1;
    step(); reset = 0;
    @(negedge Clk);
    chk("rstmid_c1_busy", 32'(MulBusy), 0);
    step(); reset = 1;
    @(negedge Clk);
    chk("rstmid_c2_busy", 32'(MulBusy), 0);
    chk("rstmid_c2_restart", 32'(StallE), 1);
    step();
    @(negedge Clk);
    chk("rstmid_c3_busy", 32'(MulBusy), 1);

    // Randomized run
    for (int i = 0; i < 3000; i++) begin
      step();
      reset = ($urandom_range(63) != 0);
      RA1D = 4'($urandom_range(3)); RA2D = 4'($urandom_range(3));
      RA1E = 4'($urandom_range(3)); RA2E = 4'($urandom_range(3));
      WA3E = 4'($urandom_range(3)); WA3M = 4'($urandom_range(3));
      WA3W = 4'($urandom_range(3));
      if ($urandom_range(7) == 0) RA1E = 4'($urandom_range(15));
      RegWriteM = 1'($urandom_range(1)); RegWriteW = 1'($urandom_range(1));
      MemToRegE = ($urandom_range(3) == 0);
      PCSrcD = ($urandom_range(7) == 0); PCSrcE = ($urandom_range(7) == 0);
      PCSrcM = ($urandom_range(7) == 0); PCSrcW = ($urandom_range(7) == 0);
      BranchTakenE = ($urandom_range(7) == 0);
      MulStartE = (m_pos >= 0) ? 1'b1 : ($urandom_range(5) == 0);
    end

    step();
    chk_en = 0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/hazard_sequencer.md
Name: hazard_sequencer

Overview:
Pipeline controller for the execute stage.
- Generates the forwarding selects for the two ALU operand muxes.
- Detects load-use and PC-write hazards and drives per-stage stall and flush signals.
- Runs a multi-cycle ALU-operation sequencer that holds the instruction in the execute stage for MUL_CYCLES cycles.
- Sits beside the fetch, decode, execute and memory pipes; its outputs go to the pipe-register enables and clears and to the execute ForwardAE/ForwardBE inputs.

Parameters:
- MUL_CYCLES, 3: total cycles a multi-cycle op occupies execute. Legal range 2..15.
- CNT_W, 4: width of the internal wait counter. Must satisfy 2^CNT_W > MUL_CYCLES.

Ports:
- Clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-low reset.
- RA1D, RA2D  in  4 each  source registers of the decode-stage instruction.
- RA1E, RA2E  in  4 each  source registers of the execute-stage instruction.
- WA3E, WA3M, WA3W  in  4 each  destination register in execute, memory and writeback.
- RegWriteM, RegWriteW  in  1 each  register-write enables, already condition-qualified.
- MemToRegE  in  1  execute instruction is a load.
- PCSrcD, PCSrcE, PCSrcM, PCSrcW  in  1 each  instruction in that stage writes the PC.
- BranchTakenE  in  1  branch resolved taken in execute.
- MulStartE  in  1  execute holds a condition-passed multi-cycle op.
- ForwardAE, ForwardBE  out  2 each  operand select: 00 = register file, 01 = ResultW, 10 = memory-stage ALU result.
- StallF, StallD, StallE  out  1 each  hold the fetch, decode and execute pipe registers.
- FlushD, FlushE, FlushM  out  1 each  clear the decode, execute and memory pipe registers.
- MulBusy  out  1  sequencer is in MULWAIT.
- MulDoneE  out  1  final execute cycle of the multi-cycle op.
- StallCount, FlushCount  out  16 each  statistics counters (see Optional Feature).

Behaviour:
Forwarding (combinational):
- ForwardAE = 10 if RegWriteM and RA1E == WA3M.
- Otherwise ForwardAE = 01 if RegWriteW and RA1E == WA3W.
- Otherwise ForwardAE = 00.
- Memory stage has priority over writeback.
- ForwardBE uses the same rules with RA2E.
- Register 15 is forwarded like any other register; no special case.

Hazard terms (combinational):
- ldrStall = MemToRegE & (RA1D == WA3E | RA2D == WA3E).
- PCWrPend = PCSrcD | PCSrcE | PCSrcM.
- mulStall = (state == RUN & MulStartE) | (state == MULWAIT & cnt != 0).

Stage outputs:
- StallF = ldrStall | PCWrPend | mulStall.
- StallD = ldrStall | mulStall.
- StallE = mulStall.
- FlushD = (PCWrPend | PCSrcW | BranchTakenE) & ~mulStall.
- FlushE = (ldrStall | BranchTakenE) & ~StallE. A stall of execute overrides its flush.
- FlushM = mulStall. This inserts a bubble into memory each stalled cycle.

State machine (registered):
- States: RUN, MULWAIT. Counter cnt is CNT_W bits wide.
- RUN with MulStartE: load cnt <= MUL_CYCLES-2, go to MULWAIT.
- RUN without MulStartE: stay in RUN.
- MULWAIT with cnt != 0: cnt <= cnt-1, stay in MULWAIT.
- MULWAIT with cnt == 0: assert MulDoneE, return to RUN.
- MulStartE is ignored while in MULWAIT; it stays high for the held instruction.
- MulBusy = (state == MULWAIT).
- Execute occupancy is exactly MUL_CYCLES cycles. Stalls are asserted for the first MUL_CYCLES-1 of them.
- A back-to-back op: MulStartE high in the cycle after return to RUN starts a new sequence with no gap.

Reset:
- reset low at a Clk edge sets state = RUN, cnt = 0 and clears the statistics counters.
- This applies mid-sequence too: the sequence is abandoned, and the next cycle sees RUN.
- While reset is low, combinational outputs still follow their equations with state = RUN.
- After release, all registered values are zero.

Optional Feature:
- Macro: HAZARD_STATS_EN.
- Defined:
  - StallCount increments each cycle StallF = 1.
  - FlushCount increments each cycle FlushE = 1.
  - Both are 16-bit and saturate at 16'hFFFF.
  - Both clear on reset.
- Undefined: both ports are driven constant 0 and no counter flops exist.

Test Plan:
- Forwarding: RegWriteM = 1, WA3M = 3, RegWriteW = 1, WA3W = 3, RA1E = 3, RA2E = 5 -> ForwardAE = 10, ForwardBE = 00. Then drop RegWriteM -> ForwardAE = 01.
- Load-use: MemToRegE = 1, WA3E = 2, RA2D = 2 for one cycle -> StallF = StallD = FlushE = 1, FlushD = 0.
- Branch: BranchTakenE = 1 with no other hazards -> FlushD = FlushE = 1, all stalls 0.
- PC write: PCSrcD then PCSrcE then PCSrcM, one cycle each -> StallF = 1 and FlushD = 1 for 3 cycles. PCSrcW next cycle -> FlushD = 1, StallF = 0.
- Multi-cycle op, MUL_CYCLES = 3: MulStartE held 3 cycles.
  - Cycles 0 and 1: StallE = FlushM = 1.
  - Cycle 1: MulBusy = 1.
  - Cycle 2: StallE = 0, MulDoneE = 1.
  - Cycle 3: state RUN.
  - Also: reset low in cycle 1 -> cycle 2 shows MulBusy = 0.
- Stats (HAZARD_STATS_EN defined): the load-use plus multi-cycle sequences above -> StallCount = 3, FlushCount = 1. With the macro undefined, both counters read 0.
